// File: rtl/caesar_pkg.sv
// rtl/caesar_pkg.sv - shared Caesar cipher defaults and FSM state encoding
package caesar_pkg;
    localparam int D_WIDTH_DEF    = 8;
    localparam int KEY_WIDTH_DEF  = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/caesar_fifo.sv
// rtl/caesar_fifo.sv - synchronous FIFO with first-word-fall-through head
module caesar_fifo #(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [D_WIDTH-1:0]       din,
    output logic [D_WIDTH-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/caesar_encryption.sv
// rtl/caesar_encryption.sv - buffered Caesar encryptor, key latched per message
module caesar_encryption
    import caesar_pkg::*;
#(
    parameter int D_WIDTH    = D_WIDTH_DEF,
    parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 ready_i,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = 1;
    localparam logic [AW:0] CNT_ZERO = 0;
    localparam logic [AW:0] CNT_FULL = FIFO_DEPTH[AW:0];

    state_t             state_q;
    state_t             state_d;
    logic [D_WIDTH-1:0] key_q;
    logic [D_WIDTH-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full_unused;
    logic [AW:0]        fifo_count;
    logic [AW:0]        cnt_nxt;
    logic               push;
    logic               pop;
    logic               key_hi_unused;

    assign key_hi_unused = ^key[KEY_WIDTH-1:D_WIDTH];

    assign push = valid_i & ~busy;
    // Output register refills whenever it is empty or being drained this cycle.
    assign pop  = ~fifo_empty & (~valid_o | ready_i);

    caesar_fifo #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i),
        .dout  (fifo_head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cnt_nxt = fifo_count + (push ? CNT_ONE : CNT_ZERO) - (pop ? CNT_ONE : CNT_ZERO);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push) state_d = ST_RUN;
            ST_RUN:  if (fifo_empty && !valid_o && !valid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (cnt_nxt == CNT_FULL);
            if (state_q == ST_IDLE && push) key_q <= key[D_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (pop) begin
            data_o  <= fifo_head + key_q;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule
